// File: rtl/spi_slave_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_slave_tx                                                 |
// | Description : MISO transmit path of the SPI slave. Bytes written over a    |
// |               valid/ready handshake are buffered in a DEPTH-entry FIFO and |
// |               serialized onto spi_miso, one bit per spi_clk. When the FIFO |
// |               is empty at a byte boundary FILL_BYTE is sent instead; once  |
// |               a real byte has gone out, such a fill sets sticky underrun.  |
// | Ports       : spi_clk    - SPI clock, all logic on posedge                 |
// |               rst        - synchronous active-high reset                   |
// |               tx_data    - byte to transmit                                |
// |               tx_valid   - tx_data valid                                   |
// |               tx_ready   - FIFO can accept a byte                          |
// |               spi_miso   - registered serial data out                      |
// |               byte_start - one-cycle pulse per byte-boundary load          |
// |               underrun   - sticky fill-after-active flag                   |
// |               level      - FIFO occupancy, 0..DEPTH                        |
// |               underrun_cnt - saturating fill count (optional)             |
// | Option      : define SPI_TX_UNDERRUN_CNT_EN to add underrun_cnt[7:0].      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_slave_tx #(
  parameter int         DEPTH     = 4,
  parameter logic [7:0] FILL_BYTE = 8'hFF,
  parameter int         MSB_FIRST = 1
) (
  input  logic                    spi_clk,
  input  logic                    rst,
  input  logic [7:0]              tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic                    spi_miso,
  output logic                    byte_start,
  output logic                    underrun,
`ifdef SPI_TX_UNDERRUN_CNT_EN
  output logic [7:0]              underrun_cnt,
`endif
  output logic [$clog2(DEPTH):0]  level
);

  localparam int            AW      = $clog2(DEPTH);
  localparam int            LW      = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          spi_miso_q, spi_miso_d;
  logic          byte_start_q, byte_start_d;
  logic          underrun_q, underrun_d;
  logic [0:0]    state_q, state_d;

  logic          w_boundary;
  logic          w_push;
  logic          w_pop;
  logic          w_fill_active;
  logic [7:0]    w_load;
  logic [7:0]    w_src;
  logic [2:0]    w_sel;

  // Ready comes only from the registered level: a full FIFO refuses a write
  // even on the cycle it pops.
  assign tx_ready      = (level_q < DEPTH_L);
  assign w_boundary    = (bit_cnt_q == 3'd0);
  assign w_push        = tx_valid && tx_ready;
  // Pop decision uses the pre-edge level, so a byte written on a boundary
  // edge is not seen by that same load.
  assign w_pop         = w_boundary && (level_q != '0);
  assign w_fill_active = w_boundary && !w_pop && (state_q == ACTIVE);
  assign w_load        = w_pop ? mem_q[rd_ptr_q] : FILL_BYTE;

  // shift_q holds the byte in flight unchanged; the bit counter selects the
  // output bit, so both bit orders share one datapath.
  assign w_src = w_boundary ? w_load : shift_q;
  assign w_sel = (MSB_FIRST != 0) ? (3'd7 - bit_cnt_q) : bit_cnt_q;

  always_comb begin
    bit_cnt_d    = bit_cnt_q + 3'd1;
    shift_d      = w_src;
    spi_miso_d   = w_src[w_sel];
    byte_start_d = w_boundary;

    wr_ptr_d = w_push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = w_pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;

    case ({w_push, w_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    mem_d = mem_q;
    if (w_push) begin
      mem_d[wr_ptr_q] = tx_data;
    end

    state_d    = state_q;
    underrun_d = underrun_q;
    if (w_pop) begin
      state_d = ACTIVE;
    end
    if (w_fill_active) begin
      underrun_d = 1'b1;
    end
  end

  always_ff @(posedge spi_clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      spi_miso_q   <= 1'b0;
      byte_start_q <= 1'b0;
      underrun_q   <= 1'b0;
      state_q      <= IDLE;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      spi_miso_q   <= spi_miso_d;
      byte_start_q <= byte_start_d;
      underrun_q   <= underrun_d;
      state_q      <= state_d;
    end
  end

  // Storage needs no reset: reset clears the pointers and level, which
  // flushes the contents logically.
  always_ff @(posedge spi_clk) begin
    mem_q <= mem_d;
  end

  assign spi_miso   = spi_miso_q;
  assign byte_start = byte_start_q;
  assign underrun   = underrun_q;
  assign level      = level_q;

`ifdef SPI_TX_UNDERRUN_CNT_EN
  logic [7:0] underrun_cnt_q, underrun_cnt_d;

  always_comb begin
    underrun_cnt_d = underrun_cnt_q;
    if (w_fill_active && (underrun_cnt_q != 8'hFF)) begin
      underrun_cnt_d = underrun_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge spi_clk) begin
    if (rst) begin
      underrun_cnt_q <= '0;
    end else begin
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign underrun_cnt = underrun_cnt_q;
`else
  // Without the counter, the sticky underrun flag is the only indication.
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_spi_slave_tx                                              |
// | Description : Self-checking bench for spi_slave_tx. A queue-based model    |
// |               tracks the FIFO contents and the byte in flight per edge.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_spi_slave_tx;

  localparam int         DEPTH     = 4;
  localparam logic [7:0] FILL_BYTE = 8'hFF;
  localparam int         MSB_FIRST = 1;
  localparam int         LW        = $clog2(DEPTH) + 1;

  logic          spi_clk;
  logic          rst;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          spi_miso;
  logic          byte_start;
  logic          underrun;
  logic [LW-1:0] level;
`ifdef SPI_TX_UNDERRUN_CNT_EN
  logic [7:0]    underrun_cnt;
`endif

  spi_slave_tx #(
    .DEPTH     (DEPTH),
    .FILL_BYTE (FILL_BYTE),
    .MSB_FIRST (MSB_FIRST)
  ) dut (
    .spi_clk      (spi_clk),
    .rst          (rst),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .spi_miso     (spi_miso),
    .byte_start   (byte_start),
    .underrun     (underrun),
`ifdef SPI_TX_UNDERRUN_CNT_EN
    .underrun_cnt (underrun_cnt),
`endif
    .level        (level)
  );

  always #5 spi_clk = ~spi_clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0] m_fifo[$];
  int         m_edge;
  logic [7:0] m_cur;
  logic       m_active;
  logic       m_underrun;
  logic       m_miso;
  logic       m_bs;
  int         m_cnt;

  logic [6:0] obs;
  assign obs = {spi_miso, byte_start, underrun, level, tx_ready};

  function automatic logic [6:0] exp_vec();
    return {m_miso, m_bs, m_underrun, LW'(m_fifo.size()), (m_fifo.size() < DEPTH)};
  endfunction

  // Drive one clock worth of inputs, advance the model, then sample point.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r);
    bit push;
    int idx;
    rst      = r;
    tx_valid = v;
    tx_data  = v ? d : 8'($urandom);
    if (r) begin
      m_fifo.delete();
      m_edge = 0; m_active = 0; m_underrun = 0;
      m_miso = 0; m_bs = 0; m_cnt = 0; m_cur = FILL_BYTE;
    end else begin
      push = v && (m_fifo.size() < DEPTH);
      idx  = m_edge % 8;
      if (idx == 0) begin
        if (m_fifo.size() > 0) begin
          m_cur    = m_fifo.pop_front();
          m_active = 1;
        end else begin
          m_cur = FILL_BYTE;
          if (m_active) begin
            m_underrun = 1;
            if (m_cnt < 255) m_cnt++;
          end
        end
      end
      if (push) m_fifo.push_back(d);
      m_miso = (MSB_FIRST != 0) ? m_cur[7-idx] : m_cur[idx];
      m_bs   = (idx == 0);
      m_edge++;
    end
    @(posedge spi_clk);
    #1;
  endtask

  task automatic do_reset();
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== 7'b000_000_1) begin
      errors++;
      $display("FAIL reset {miso,bs,ur,level,ready} got=%b exp=%b", obs, 7'b0000001);
    end
`ifdef SPI_TX_UNDERRUN_CNT_EN
    checks++;
    if (underrun_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_cnt got=%0d exp=0", underrun_cnt);
    end
`endif
  endtask

  task automatic test_idle();
    do_reset();
    for (int e = 0; e < 24; e++) begin
      cycle(1'b0, 8'h00, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL idle e=%0d got=%b exp=%b", e, obs, exp_vec());
      end
      checks++;
      if (byte_start !== (e % 8 == 0) || spi_miso !== 1'b1 || underrun !== 1'b0) begin
        errors++;
        $display("FAIL idle_fill e=%0d bs=%b miso=%b ur=%b exp bs=%b miso=1 ur=0",
                 e, byte_start, spi_miso, underrun, (e % 8 == 0));
      end
    end
  endtask

  task automatic test_single_byte();
    logic [7:0] exp_byte;
    exp_byte = 8'hA5;
    do_reset();
    for (int e = 0; e < 16; e++) begin
      cycle((e == 1), 8'hA5, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL single e=%0d got=%b exp=%b", e, obs, exp_vec());
      end
      if (e == 7 || e == 8) begin
        checks++;
        if (level !== ((e == 7) ? 3'd1 : 3'd0)) begin
          errors++;
          $display("FAIL single_level e=%0d got=%0d exp=%0d", e, level, (e == 7) ? 1 : 0);
        end
      end
      if (e >= 8) begin
        checks++;
        if (spi_miso !== exp_byte[15-e]) begin
          errors++;
          $display("FAIL single_bit e=%0d got=%b exp=%b", e, spi_miso, exp_byte[15-e]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] wr [4];
    logic [7:0] exp_b [5];
    logic [7:0] got;
    bit         acc;
    wr    = '{8'h3C, 8'hC3, 8'h01, 8'h80};
    exp_b = '{8'h3C, 8'hC3, 8'h01, 8'h80, 8'h55};
    got   = 8'h00;
    acc   = 0;
    do_reset();
    for (int e = 0; e < 48; e++) begin
      if (e >= 1 && e <= 4) begin
        cycle(1'b1, wr[e-1], 1'b0);
      end else if (e >= 5 && !acc) begin
        if (e == 5) begin
          checks++;
          if (tx_ready !== 1'b0 || level !== 3'd4) begin
            errors++;
            $display("FAIL b2b_full ready=%b level=%0d exp ready=0 level=4", tx_ready, level);
          end
        end
        acc = tx_ready;
        cycle(1'b1, 8'h55, 1'b0);
      end else begin
        cycle(1'b0, 8'h00, 1'b0);
      end
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL b2b e=%0d got=%b exp=%b", e, obs, exp_vec());
      end
      got = {got[6:0], spi_miso};
      if (e >= 15 && e % 8 == 7) begin
        checks++;
        if (got !== exp_b[e/8-1]) begin
          errors++;
          $display("FAIL b2b_byte n=%0d got=%h exp=%h", e/8-1, got, exp_b[e/8-1]);
        end
      end
    end
  endtask

  task automatic test_underrun();
    do_reset();
    for (int e = 0; e < 33; e++) begin
      cycle((e == 1), 8'h00, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL underrun e=%0d got=%b exp=%b", e, obs, exp_vec());
      end
      if (e == 15 || e == 16 || e == 32) begin
        checks++;
        if (underrun !== (e != 15) || byte_start !== (e != 15)) begin
          errors++;
          $display("FAIL underrun_edge e=%0d ur=%b bs=%b exp=%b", e, underrun, byte_start, (e != 15));
        end
      end
`ifdef SPI_TX_UNDERRUN_CNT_EN
      checks++;
      if (underrun_cnt !== 8'(m_cnt)) begin
        errors++;
        $display("FAIL underrun_cnt e=%0d got=%0d exp=%0d", e, underrun_cnt, m_cnt);
      end
      if (e == 16 || e == 32) begin
        checks++;
        if (underrun_cnt !== ((e == 16) ? 8'd1 : 8'd3)) begin
          errors++;
          $display("FAIL underrun_cnt_fixed e=%0d got=%0d exp=%0d", e, underrun_cnt, (e == 16) ? 1 : 3);
        end
      end
`endif
    end
  endtask

  task automatic test_boundary_write();
    logic [7:0] got;
    got = 8'h00;
    do_reset();
    for (int e = 0; e < 16; e++) begin
      cycle((e == 0), 8'h77, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL bwrite e=%0d got=%b exp=%b", e, obs, exp_vec());
      end
      if (e == 0 || e == 4) begin
        checks++;
        if (level !== 3'd1 || spi_miso !== 1'b1) begin
          errors++;
          $display("FAIL bwrite_fill e=%0d level=%0d miso=%b exp level=1 miso=1", e, level, spi_miso);
        end
      end
      got = {got[6:0], spi_miso};
      if (e == 15) begin
        checks++;
        if (got !== 8'h77) begin
          errors++;
          $display("FAIL bwrite_byte got=%h exp=77", got);
        end
      end
    end
  endtask

  task automatic test_reset_mid_byte();
    do_reset();
    for (int e = 0; e < 4; e++) begin
      cycle((e == 1 || e == 2), 8'h11 * 8'(e), 1'b0);
    end
    checks++;
    if (level !== 3'd2) begin
      errors++;
      $display("FAIL midrst_pre level got=%0d exp=2", level);
    end
    cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (obs !== 7'b000_000_1) begin
      errors++;
      $display("FAIL midrst_after got=%b exp=%b", obs, 7'b0000001);
    end
    cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (spi_miso !== 1'b1 || byte_start !== 1'b1 || level !== 3'd0) begin
      errors++;
      $display("FAIL midrst_fill miso=%b bs=%b level=%0d exp 1 1 0", spi_miso, byte_start, level);
    end
  endtask

  task automatic test_random();
    logic v;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      v = ($urandom_range(0, 99) < ((i < 400) ? 20 : 8));
      cycle(v, 8'($urandom), 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL random i=%0d got=%b exp=%b", i, obs, exp_vec());
      end
`ifdef SPI_TX_UNDERRUN_CNT_EN
      checks++;
      if (underrun_cnt !== 8'(m_cnt)) begin
        errors++;
        $display("FAIL random_cnt i=%0d got=%0d exp=%0d", i, underrun_cnt, m_cnt);
      end
`endif
    end
  endtask

  initial begin
    spi_clk  = 1'b0;
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    test_reset();
    test_idle();
    test_single_byte();
    test_back_to_back();
    test_underrun();
    test_boundary_write();
    test_reset_mid_byte();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
